// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory stage: EX->MEM bus field layout, transfer
// size encodings and the request FSM state encoding.
package mem_stage_ctrl_pkg;

  localparam int ADDR_LSB  = 0;
  localparam int WDATA_LSB = 32;
  localparam int SIZE_LSB  = 64;
  localparam int WE_BIT    = 66;
  localparam int REQ_BIT   = 67;
  localparam int UNS_BIT   = 68;
  localparam int ALU_LSB   = 69;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } mem_state_e;

  // Low part of the EX->MEM bus, packed MSB first so a cast lines up with the bus.
  typedef struct packed {
    logic        uns;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] addr;
  } ex_req_t;

  localparam int EX_REQ_W = $bits(ex_req_t);

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-SRAM request/response bus between the memory stage (master) and the
// data SRAM (slave).
interface mem_stage_ctrl_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/mem_load_ext.sv
// Load data lane select plus sign/zero extension for byte, half and word loads.
module mem_load_ext
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~uns & byte_lane[7]}}, byte_lane};
      SIZE_HALF: data = {{16{~uns & half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage control: data-SRAM handshake, load extraction and MEM->WB
// valid/bus generation. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int PC_INST_W = 64,
  parameter int EX_MEM_W  = 104,
  parameter int MEM_WB_W  = 104
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid_i,
  input  logic [PC_INST_W-1:0] pc_inst_ibus,
  input  logic [EX_MEM_W-1:0]  ex_to_mem_ibus,
  output logic                 mem_allowin_o,
  input  logic                 wb_allowin_i,
  output logic                 mem_to_wb_valid_o,
  output logic [PC_INST_W-1:0] pc_inst_obus,
  output logic [MEM_WB_W-1:0]  mem_to_wb_obus,
  mem_stage_ctrl_if.master     sram,
  output logic                 mem_ale_o
);

  ex_req_t     ex;
  logic [31:0] alu_res;
  logic        ale;
  logic        is_mem;
  logic        ready_go;
  mem_state_e  state;
  logic [31:0] rbuf;
  logic [31:0] ld_src;
  logic [31:0] ld_data;
  logic [31:0] result;

  assign ex      = ex_req_t'(ex_to_mem_ibus[EX_REQ_W-1:0]);
  assign alu_res = ex_to_mem_ibus[ALU_LSB +: 32];

`ifdef MEM_ALIGN_CHECK_EN
  assign ale = ex.req & (((ex.size == SIZE_HALF) & ex.addr[0]) |
                         ((ex.size == SIZE_WORD) & (|ex.addr[1:0])));
  assign mem_ale_o = mem_valid_i & ale;
`else
  assign ale       = 1'b0;
  assign mem_ale_o = 1'b0;
`endif

  // A trapped access never reaches the SRAM and passes straight through.
  assign is_mem = mem_valid_i & ex.req & ~ale;

  assign ready_go = ~is_mem
                  | ((state == ST_WAIT) & sram.data_sram_data_ok)
                  | (state == ST_HOLD);

  assign mem_allowin_o     = ~mem_valid_i | (ready_go & wb_allowin_i);
  assign mem_to_wb_valid_o = mem_valid_i & ready_go;

  // Request fields stay stable while req is high because allowin holds the EX bus.
  assign sram.data_sram_req   = (state == ST_IDLE) & is_mem;
  assign sram.data_sram_wr    = ex.we;
  assign sram.data_sram_size  = ex.size;
  assign sram.data_sram_addr  = ex.addr;
  assign sram.data_sram_wdata = ex.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rbuf  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (is_mem && sram.data_sram_addr_ok) state <= ST_WAIT;
        ST_WAIT: begin
          if (sram.data_sram_data_ok) begin
            if (wb_allowin_i) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_HOLD;
              rbuf  <= sram.data_sram_rdata;
            end
          end
        end
        ST_HOLD: if (wb_allowin_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response is bypassed in WAIT and replayed from the buffer while WB stalls.
  assign ld_src = (state == ST_HOLD) ? rbuf : sram.data_sram_rdata;

  mem_load_ext u_load_ext (
    .rdata   (ld_src),
    .addr_lo (ex.addr[1:0]),
    .size    (ex.size),
    .uns     (ex.uns),
    .data    (ld_data)
  );

  always_comb begin
    result = alu_res;
    if (is_mem) result = ex.we ? 32'h0 : ld_data;
  end

  assign pc_inst_obus   = pc_inst_ibus;
  assign mem_to_wb_obus = {result, ex_to_mem_ibus[EX_MEM_W-1 -: MEM_WB_W-32]};

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a transaction-level
// reference model, plus directed load, stall, reset and alignment scenarios.
module tb_mem_stage_ctrl;

  localparam int PC_INST_W = 64;
  localparam int EX_MEM_W  = 104;
  localparam int MEM_WB_W  = 104;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 mem_valid_i;
  logic [PC_INST_W-1:0] pc_inst_ibus;
  logic [EX_MEM_W-1:0]  ex_to_mem_ibus;
  logic                 mem_allowin_o;
  logic                 wb_allowin_i;
  logic                 mem_to_wb_valid_o;
  logic [PC_INST_W-1:0] pc_inst_obus;
  logic [MEM_WB_W-1:0]  mem_to_wb_obus;
  logic                 mem_ale_o;

  mem_stage_ctrl_if sram ();

  mem_stage_ctrl #(
    .PC_INST_W (PC_INST_W),
    .EX_MEM_W  (EX_MEM_W),
    .MEM_WB_W  (MEM_WB_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid_i       (mem_valid_i),
    .pc_inst_ibus      (pc_inst_ibus),
    .ex_to_mem_ibus    (ex_to_mem_ibus),
    .mem_allowin_o     (mem_allowin_o),
    .wb_allowin_i      (wb_allowin_i),
    .mem_to_wb_valid_o (mem_to_wb_valid_o),
    .pc_inst_obus      (pc_inst_obus),
    .mem_to_wb_obus    (mem_to_wb_obus),
    .sram              (sram),
    .mem_ale_o         (mem_ale_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction currently presented on the EX->MEM bus
  logic [31:0] i_addr, i_wdata, i_alu;
  logic [1:0]  i_size;
  logic        i_we, i_req, i_uns;
  logic [2:0]  i_misc;
  logic [63:0] i_pc;

  // Transaction progress of the instruction held in MEM
  bit          addr_taken, data_held, retired;
  logic [31:0] held_data;
  int          beats;
  bit          e_ready, e_mem;

  task automatic apply_bus();
    ex_to_mem_ibus = {i_misc, i_alu, i_uns, i_req, i_we, i_size, i_wdata, i_addr};
    pc_inst_ibus   = i_pc;
  endtask

  task automatic new_instr(input logic [31:0] a, input logic [1:0] sz, input logic we,
                           input logic rq, input logic u);
    i_addr = a; i_size = sz; i_we = we; i_req = rq; i_uns = u;
    i_wdata = $urandom; i_alu = $urandom; i_misc = 3'($urandom);
    i_pc = {$urandom, $urandom};
    apply_bus();
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    longint unsigned v;
    if (sz == 2'd0) begin
      v = (longint'(d) >> (8 * (a % 4))) % 256;
      if (!u && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (longint'(d) >> (16 * ((a / 2) % 2))) % 65536;
      if (!u && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(d);
    end
    return v[31:0];
  endfunction

  function automatic bit ref_ale();
`ifdef MEM_ALIGN_CHECK_EN
    return i_req && ((i_size == 2'd1 && i_addr % 2 != 0) || (i_size == 2'd2 && i_addr % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_req();
    return mem_valid_i && i_req && !ref_ale() && !addr_taken;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic sample();
    logic [31:0]  res;
    logic [103:0] obus;
    bit           req_e;
    @(negedge clk);
    e_mem   = mem_valid_i && i_req && !ref_ale();
    e_ready = !e_mem || (addr_taken && !data_held && sram.data_sram_data_ok) || data_held;
    req_e   = e_mem && !addr_taken;
    if (!e_mem)    res = i_alu;
    else if (i_we) res = 32'h0;
    else           res = ref_load(data_held ? held_data : sram.data_sram_rdata, i_addr, i_size, i_uns);
    obus = {res, i_misc, i_alu, i_uns, i_req, i_we, i_size, i_wdata};
    check_val("req", sram.data_sram_req, req_e);
    if (req_e) begin
      check_val("addr", sram.data_sram_addr, i_addr);
      check_val("wr", sram.data_sram_wr, i_we);
      check_val("size", sram.data_sram_size, i_size);
      check_val("wdata", sram.data_sram_wdata, i_wdata);
    end
    check_val("valid", mem_to_wb_valid_o, mem_valid_i && e_ready);
    check_val("allowin", mem_allowin_o, !mem_valid_i || (e_ready && wb_allowin_i));
    check_val("obus", mem_to_wb_obus, obus);
    check_val("pc", pc_inst_obus, i_pc);
    check_val("ale", mem_ale_o, mem_valid_i && ref_ale());
  endtask

  task automatic advance();
    @(posedge clk);
    retired = 1'b0;
    if (mem_valid_i && wb_allowin_i && e_ready) begin
      beats++;
      addr_taken = 1'b0;
      data_held  = 1'b0;
      retired    = 1'b1;
    end else if (e_mem) begin
      if (!addr_taken && sram.data_sram_addr_ok) begin
        addr_taken = 1'b1;
      end else if (addr_taken && !data_held && sram.data_sram_data_ok) begin
        data_held = 1'b1;
        held_data = sram.data_sram_rdata;
      end
    end
    #1;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] rd, input logic [31:0] exp_res,
                          input int aok_wait, input int stall);
    int b0;
    new_instr(a, sz, 1'b0, 1'b1, u);
    mem_valid_i = 1'b1; wb_allowin_i = 1'b1;
    sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b0;
    for (int k = 0; k < aok_wait; k++) begin
      sample();
      check_val("req_held", sram.data_sram_req, 1'b1);
      check_val("addr_held", sram.data_sram_addr, a);
      advance();
    end
    sram.data_sram_addr_ok = 1'b1;
    sample();
    check_val("req_issue", sram.data_sram_req, 1'b1);
    advance();
    sram.data_sram_addr_ok = 1'b0;
    sram.data_sram_data_ok = 1'b1;
    sram.data_sram_rdata   = rd;
    wb_allowin_i = (stall == 0);
    b0 = beats;
    sample();
    if (stall == 0) begin
      check_val("load_res", mem_to_wb_obus[103:72], exp_res);
      check_val("load_valid", mem_to_wb_valid_o, 1'b1);
    end
    advance();
    sram.data_sram_data_ok = 1'b0;
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        sram.data_sram_rdata = $urandom;
        sample();
        check_val("hold_allowin", mem_allowin_o, 1'b0);
        advance();
      end
      wb_allowin_i = 1'b1;
      sram.data_sram_rdata = $urandom;
      sample();
      check_val("hold_res", mem_to_wb_obus[103:72], exp_res);
      check_val("hold_valid", mem_to_wb_valid_o, 1'b1);
      advance();
    end
    check_val("one_beat", beats - b0, 1);
    mem_valid_i = 1'b0;
  endtask

  initial begin
    bit need_new;
    rst_n = 1'b0;
    mem_valid_i = 1'b0; wb_allowin_i = 1'b0;
    sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b0; sram.data_sram_rdata = '0;
    i_addr = '0; i_wdata = '0; i_alu = '0; i_size = '0; i_we = 1'b0; i_req = 1'b0;
    i_uns = 1'b0; i_misc = '0; i_pc = '0;
    addr_taken = 1'b0; data_held = 1'b0; retired = 1'b0; held_data = '0; beats = 0;
    apply_bus();

    // Reset values
    sample();
    check_val("rst_allowin", mem_allowin_o, 1'b1);
    check_val("rst_valid", mem_to_wb_valid_o, 1'b0);
    check_val("rst_req", sram.data_sram_req, 1'b0);
    check_val("rst_obus", mem_to_wb_obus, '0);
    advance();
    rst_n = 1'b1;
    advance();

    // ALU op passes in the same cycle
    new_instr(32'h0000_0040, 2'd2, 1'b0, 1'b0, 1'b0);
    mem_valid_i = 1'b1; wb_allowin_i = 1'b1;
    sample();
    check_val("alu_valid", mem_to_wb_valid_o, 1'b1);
    check_val("alu_allowin", mem_allowin_o, 1'b1);
    check_val("alu_res", mem_to_wb_obus[103:72], i_alu);
    advance();

    run_load(32'h0000_1003, 2'd0, 1'b0, 32'h80FF_FF00, 32'hFFFF_FF80, 0, 0);
    run_load(32'h0000_2002, 2'd1, 1'b1, 32'hBEEF_1234, 32'h0000_BEEF, 0, 0);
    run_load(32'h0000_2000, 2'd1, 1'b0, 32'h1234_8001, 32'hFFFF_8001, 0, 3);
    run_load(32'h0000_4001, 2'd0, 1'b1, 32'h0000_A500, 32'h0000_00A5, 4, 0);

    // Reset pulsed while waiting for data_ok
    new_instr(32'h0000_5000, 2'd2, 1'b0, 1'b1, 1'b0);
    mem_valid_i = 1'b1; wb_allowin_i = 1'b1;
    sram.data_sram_addr_ok = 1'b1;
    sample();
    advance();
    sram.data_sram_addr_ok = 1'b0;
    sample();
    advance();
    rst_n = 1'b0;
    mem_valid_i = 1'b0;
    new_instr(32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    i_alu = '0; i_wdata = '0; i_misc = '0; i_pc = '0;
    apply_bus();
    addr_taken = 1'b0; data_held = 1'b0;
    sample();
    check_val("mid_rst_allowin", mem_allowin_o, 1'b1);
    check_val("mid_rst_valid", mem_to_wb_valid_o, 1'b0);
    check_val("mid_rst_req", sram.data_sram_req, 1'b0);
    check_val("mid_rst_obus", mem_to_wb_obus, '0);
    advance();
    rst_n = 1'b1;
    run_load(32'h0000_6004, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
    new_instr(32'h0000_3002, 2'd2, 1'b0, 1'b1, 1'b0);
    mem_valid_i = 1'b1; wb_allowin_i = 1'b1;
    sample();
    check_val("ale_flag", mem_ale_o, 1'b1);
    check_val("ale_req", sram.data_sram_req, 1'b0);
    check_val("ale_valid", mem_to_wb_valid_o, 1'b1);
    advance();
    mem_valid_i = 1'b0;
`endif

    // Randomized traffic with a responsive SRAM and a randomly stalling WB
    need_new = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (need_new) begin
        mem_valid_i = ($urandom % 5) != 0;
        new_instr($urandom, 2'($urandom % 3), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      wb_allowin_i = ($urandom % 4) != 0;
      sram.data_sram_rdata   = $urandom;
      sram.data_sram_addr_ok = exp_req() && (($urandom % 3) == 0);
      sram.data_sram_data_ok = addr_taken && !data_held && (($urandom % 3) == 0);
      sample();
      advance();
      need_new = retired || !mem_valid_i;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage control block, downstream consumer of the EX→MEM pipeline register. It takes `mem_valid_i` and the registered EX bus, and produces `mem_allowin_o` back to the register. It runs the data-SRAM request/response handshake for loads and stores, and extracts and extends load data. It drives the valid/bus pair into the MEM→WB register, buffering a response whenever WB stalls.

## Interface
Parameters:
- `PC_INST_W`, 64: width of the pc/inst bus (`PcInstBusLen`).
- `EX_MEM_W`, 104: width of the EX→MEM bus (`ExToMemBusLen`).
- `MEM_WB_W`, 104: width of the MEM→WB bus (`MemToWbBusLen`).

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `mem_valid_i`, in, 1: MEM holds a valid instruction.
- `pc_inst_ibus`, in, PC_INST_W: forwarded unchanged to `pc_inst_obus`.
- `ex_to_mem_ibus`, in, EX_MEM_W: registered EX result.
- `mem_allowin_o`, out, 1: MEM accepts a new instruction at the next edge.
- `wb_allowin_i`, in, 1: WB accepts.
- `mem_to_wb_valid_o`, out, 1: valid into MEM→WB.
- `pc_inst_obus`, out, PC_INST_W: pc/inst passthrough.
- `mem_to_wb_obus`, out, MEM_WB_W: {result[31:0], passthrough}.
- `data_sram_req`, out, 1: request.
- `data_sram_wr`, out, 1: write.
- `data_sram_size`, out, 2: transfer size.
- `data_sram_addr`, out, 32: address.
- `data_sram_wdata`, out, 32: write data.
- `data_sram_addr_ok`, in, 1: request accepted.
- `data_sram_data_ok`, in, 1: response valid.
- `data_sram_rdata`, in, 32: read data.
- `mem_ale_o`, out, 1: misaligned-access flag.

## Operation
EX bus fields, low bits first:
- [31:0] `addr`
- [63:32] `wdata`
- [65:64] `size` (00 byte, 01 half, 10 word)
- [66] `we`
- [67] `req`
- [68] `unsigned`
- [103:69] passthrough (alu result in [100:69])

Memory op definition: `is_mem = mem_valid_i & req & ~ale`.

FSM states:
- IDLE:
  - `data_sram_req = is_mem`.
  - `addr_ok` → WAIT.
- WAIT:
  - req low.
  - `data_ok & wb_allowin_i` → IDLE; result bypassed combinationally.
  - `data_ok & ~wb_allowin_i` → HOLD; `rdata` captured in `rbuf`.
- HOLD: `wb_allowin_i` → IDLE; result taken from `rbuf`.

Handshake equations:
- `ready_go = ~is_mem | (state==WAIT & data_ok) | state==HOLD`.
- `mem_allowin_o = ~mem_valid_i | (ready_go & wb_allowin_i)`.
- `mem_to_wb_valid_o = mem_valid_i & ready_go`.

Request rules:
- Request fields are combinational from the bus.
- Request fields are held stable while req is high.

Load extraction:
- The lane is selected by `addr[1:0]`.
- Byte: sign- or zero-extend by `unsigned`.
- Half: uses `addr[1]`; sign- or zero-extend by `unsigned`.
- Word: unchanged.

Store results:
- Store write data is presented as-is; byte-lane replication is done by EX.
- Stores report `result = 0`.
- Non-memory instructions pass alu result [100:69].

Protocol assumptions:
- `data_ok` never arrives in the same cycle as its own `addr_ok`.
- `data_ok` outside WAIT is ignored.

## Timing
Reset values:
- `state` = IDLE, `rbuf` = 0.
- Outputs under reset (`mem_valid_i` = 0): `mem_allowin_o` = 1, all other outputs 0.

Latency:
- Non-memory instruction: 0 added cycles.
- Load/store: 1 cycle minimum (`addr_ok` in cycle 0, `data_ok` in cycle 1).

Boundary conditions:
- WB stall at `data_ok`: the response is never lost; `rbuf` holds it until `wb_allowin_i`.
- Back-to-back memory ops: the next request issues the cycle after the previous exit to IDLE.
- Reset mid-transaction: FSM returns to IDLE. The data SRAM shares `rst_n`, so no stale `data_ok` follows.
- `mem_valid_i` low in WAIT cannot occur, because allowin was held low.

## Configuration
`MEM_ALIGN_CHECK_EN` defined:
- `ale` is set for half with `addr[0]`, or word with `addr[1:0]` != 0, when `req` is set.
- `mem_ale_o = mem_valid_i & ale`.
- No request issues; the instruction passes with `ready_go = 1`.

`MEM_ALIGN_CHECK_EN` undefined:
- `ale = 0`; `mem_ale_o` is tied 0.
- The address is issued unmodified.

## Structure
Shared header `DefineLoogLenWidth.h`:
- `MemToWbBusLen`/`MemToWbBusWidth`.
- EX bus field offsets.
- Size encodings.
- FSM state encodings.

Sub-module `mem_load_ext`: combinational lane select plus sign/zero extension (rdata, addr[1:0], size, unsigned → 32-bit).

## Test plan
- ALU op, `wb_allowin_i` = 1:
  - `mem_to_wb_valid_o` is 1 in the same cycle; `mem_allowin_o` = 1.
  - result equals bus[100:69].
- `ld.b` addr 0x1003, rdata 0x80FF_FF00, signed:
  - `addr_ok` in cycle 0, `data_ok` in cycle 1.
  - result 0xFFFF_FF80 in cycle 1.
- `ld.hu` addr 0x2002, rdata 0xBEEF_1234: result 0x0000_BEEF.
- Load with `wb_allowin_i` = 0 at `data_ok`:
  - HOLD lasts 3 cycles with `mem_allowin_o` = 0.
  - `rbuf` is released when `wb_allowin_i` rises; exactly one valid beat.
- `addr_ok` withheld 4 cycles:
  - req and addr stay stable.
  - `rst_n` pulsed in WAIT → IDLE, all outputs at reset values.
- `MEM_ALIGN_CHECK_EN`, `ld.w` at 0x3002:
  - `mem_ale_o` = 1; `data_sram_req` stays 0; instruction forwarded the same cycle.
